macu_seq: RTL and testbench

//  Initiator/sequencer for the macu multiply-accumulate unit: takes one dot-product job
//  (bias + len operand pairs), streams the pairs into macu on xi/wi and feeds each partial
//  sum back on ci, then returns the clipped result over a valid/ready port.

---
 rtl/macu_seq_pkg.sv | 16 +
 rtl/macu_seq_sat_clip.sv | 13 +
 rtl/macu_seq.sv | 105 ++++++++++
 tb/tb_macu_seq.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/macu_seq_pkg.sv
// Shared definitions for the macu sequencer: FSM state encoding and default sizing.
package macu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DW      = 8;
  localparam int DEF_CW      = 16;
  localparam int DEF_LW      = 8;
  localparam int DEF_MAC_LAT = 1;

endpackage

// File: rtl/macu_seq_sat_clip.sv
// Clips a (CW+1)-bit unsigned macu sum to CW bits; ovf flags that the top bit was set.
module macu_seq_sat_clip #(
  parameter int CW = 16
) (
  input  logic [CW:0]   din,
  output logic [CW-1:0] dout,
  output logic          ovf
);

  assign ovf  = din[CW];
  assign dout = din[CW] ? {CW{1'b1}} : din[CW-1:0];

endmodule

// File: rtl/macu_seq.sv
// Dot-product sequencer: streams operand pairs into one macu, feeds each partial sum
// back on ci, and returns the clipped accumulator over a valid/ready result port.
module macu_seq
  import macu_seq_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int CW      = DEF_CW,
  parameter int LW      = DEF_LW,
  parameter int MAC_LAT = DEF_MAC_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [CW-1:0] bias,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_x,
  input  logic [DW-1:0] in_w,
  output logic [DW-1:0] mac_xi,
  output logic [DW-1:0] mac_wi,
  output logic [CW-1:0] mac_ci,
  input  logic [CW:0]   mac_co,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_data,
  output logic          res_sat
);

  localparam int CNTW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  state_t          state;
  logic [CW-1:0]   acc;
  logic [LW-1:0]   rem;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   clip_data;
  logic            clip_ovf;

  macu_seq_sat_clip #(.CW(CW)) u_clip (
    .din  (mac_co),
    .dout (clip_data),
    .ovf  (clip_ovf)
  );

  // Handshake flags decode straight from the registered state.
  assign busy      = (state != IDLE);
  assign in_ready  = (state == ISSUE);
  assign res_valid = (state == DONE);
  assign res_data  = acc;

  // Job sequencing FSM with its counters, operand and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= {CW{1'b0}};
      rem     <= {LW{1'b0}};
      cnt     <= {CNTW{1'b0}};
      mac_xi  <= {DW{1'b0}};
      mac_wi  <= {DW{1'b0}};
      mac_ci  <= {CW{1'b0}};
      res_sat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= bias;
            rem     <= len;
            res_sat <= 1'b0;
            state   <= (len == {LW{1'b0}}) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (in_valid) begin
            mac_xi <= in_x;
            mac_wi <= in_w;
            mac_ci <= acc;
            cnt    <= CNTW'(MAC_LAT);
            state  <= WAIT;
          end
        end
        WAIT: begin
          // cnt reaches zero exactly when macu has presented co for the last issue
          if (cnt != {CNTW{1'b0}}) begin
            cnt <= cnt - CNTW'(1);
          end else begin
            acc     <= clip_data;
            res_sat <= res_sat | clip_ovf;
            rem     <= rem - LW'(1);
            state   <= (rem == LW'(1)) ? DONE : ISSUE;
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_macu_seq.sv
// Self-checking bench for macu_seq: behavioural macu model plus a plain-arithmetic
// dot-product reference, with directed and randomized jobs.
module tb_macu_seq;

  localparam int DW      = 8;
  localparam int CW      = 16;
  localparam int LW      = 8;
  localparam int MAC_LAT = 1;
  localparam int MAXV    = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [CW-1:0] bias = '0;
  logic          busy;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_x = '0;
  logic [DW-1:0] in_w = '0;
  logic [DW-1:0] mac_xi;
  logic [DW-1:0] mac_wi;
  logic [CW-1:0] mac_ci;
  logic [CW:0]   mac_co;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [CW-1:0] res_data;
  logic          res_sat;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  int          xs [256];
  int          ws [256];
  int          exp_data;
  bit          exp_sat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  macu_seq #(.DW(DW), .CW(CW), .LW(LW), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .mac_xi(mac_xi), .mac_wi(mac_wi), .mac_ci(mac_ci), .mac_co(mac_co),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_sat(res_sat)
  );

  // Behavioural macu: co = xi*wi+ci after MAC_LAT register stages.
  logic [CW:0] pipe [MAC_LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAC_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= (CW+1)'(mac_xi) * (CW+1)'(mac_wi) + (CW+1)'(mac_ci);
      for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mac_co = pipe[MAC_LAT-1];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Dot product with saturation at every partial sum.
  task automatic ref_model(input int n, input int b);
    int a;
    int s;
    a = b;
    exp_sat = 1'b0;
    for (int k = 0; k < n; k++) begin
      s = xs[k] * ws[k] + a;
      if (s > MAXV) begin
        a = MAXV;
        exp_sat = 1'b1;
      end else begin
        a = s;
      end
    end
    exp_data = a;
  endtask

  task automatic run_job(input int n, input int b, input int gap, input int hold,
                         input bit poke, input string name);
    int          t;
    int unsigned last_acc;
    bit          stable;
    ref_model(n, b);
    start = 1'b1;
    len   = n[LW-1:0];
    bias  = b[CW-1:0];
    tick();
    start = 1'b0;
    len   = LW'($urandom);
    bias  = CW'($urandom);
    if (n == 0) begin
      n_tests++;
      if (res_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s len0_latency: res_valid got %b want 1", name, res_valid);
      end
    end
    last_acc = 0;
    for (int k = 0; k < n; k++) begin
      repeat (gap) tick();
      in_x = xs[k][DW-1:0];
      in_w = ws[k][DW-1:0];
      in_valid = 1'b1;
      t = 0;
      while (in_ready !== 1'b1 && t < 50) begin
        tick();
        t++;
      end
      if (t >= 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s in_ready_timeout: pair %0d never accepted", name, k);
        in_valid = 1'b0;
        return;
      end
      if (gap == 0 && k > 0) begin
        n_tests++;
        if (cyc - last_acc != MAC_LAT + 2) begin
          n_fail++;
          $display("FAIL %s issue_spacing: got %0d cycles want %0d", name, cyc - last_acc, MAC_LAT + 2);
        end
      end
      last_acc = cyc;
      tick();
      in_valid = 1'b0;
      in_x = DW'($urandom);
      in_w = DW'($urandom);
      if (poke && k == 0) begin
        start = 1'b1;
        len   = LW'(7);
        bias  = CW'($urandom);
        tick();
        start = 1'b0;
      end
    end
    t = 0;
    while (res_valid !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    n_tests++;
    if (t >= 50) begin
      n_fail++;
      $display("FAIL %s res_timeout: res_valid never rose", name);
      return;
    end
    if (res_data !== exp_data[CW-1:0] || res_sat !== exp_sat || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s result: data=%0d sat=%b busy=%b want data=%0d sat=%b busy=1",
               name, res_data, res_sat, busy, exp_data, exp_sat);
    end
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        tick();
        if (res_valid !== 1'b1 || res_data !== exp_data[CW-1:0] || res_sat !== exp_sat || busy !== 1'b1)
          stable = 1'b0;
      end
      n_tests++;
      if (stable !== 1'b1) begin
        n_fail++;
        $display("FAIL %s result_hold: got valid=%b data=%0d sat=%b busy=%b want held result %0d/%b",
                 name, res_valid, res_data, res_sat, busy, exp_data, exp_sat);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: res_valid=%b busy=%b want 0 0", name, res_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, in_ready, res_valid, res_sat, res_data, mac_xi, mac_wi, mac_ci} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b rdy=%b val=%b sat=%b data=%0d xi=%0d wi=%0d ci=%0d want all 0",
               busy, in_ready, res_valid, res_sat, res_data, mac_xi, mac_wi, mac_ci);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      xs[k] = k + 1;
      ws[k] = 1;
    end
    run_job(3, 0, 0, 0, 1'b0, "back_to_back");
  endtask

  task automatic test_gapped();
    for (int k = 0; k < 4; k++) begin
      xs[k] = k + 1;
      ws[k] = 16;
    end
    run_job(4, 10, 0, 0, 1'b0, "dense4");
    run_job(4, 10, 5, 0, 1'b0, "gapped4");
  endtask

  task automatic test_saturation();
    xs[0] = 255; ws[0] = 255;
    xs[1] = 255; ws[1] = 255;
    run_job(2, 'hFF00, 0, 2, 1'b0, "saturate");
    xs[0] = 0; ws[0] = 0;
    run_job(1, 7, 0, 0, 1'b0, "sat_cleared");
  endtask

  task automatic test_len_zero();
    run_job(0, 5, 0, 10, 1'b0, "len_zero");
  endtask

  task automatic test_start_ignored();
    bit idle_ok;
    for (int k = 0; k < 2; k++) begin
      xs[k] = $urandom_range(1, 255);
      ws[k] = $urandom_range(1, 255);
    end
    run_job(2, $urandom_range(0, 1000), 0, 0, 1'b1, "start_in_wait");
    idle_ok = 1'b1;
    repeat (3) begin
      tick();
      if (busy !== 1'b0 || res_valid !== 1'b0) idle_ok = 1'b0;
    end
    n_tests++;
    if (idle_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL no_queued_job: busy=%b res_valid=%b want 0 0", busy, res_valid);
    end
    xs[0] = 3; ws[0] = 4;
    run_job(1, 100, 0, 0, 1'b0, "after_ignored");
  endtask

  task automatic test_reset_mid_job();
    start = 1'b1;
    len   = LW'(2);
    bias  = CW'(1234);
    tick();
    start = 1'b0;
    in_x = DW'(200);
    in_w = DW'(150);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, in_ready, res_valid, res_sat, res_data, mac_xi, mac_wi, mac_ci} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_job: busy=%b rdy=%b val=%b sat=%b data=%0d xi=%0d wi=%0d ci=%0d want all 0",
               busy, in_ready, res_valid, res_sat, res_data, mac_xi, mac_wi, mac_ci);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    n_tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_result: busy=%b res_valid=%b want 0 0", busy, res_valid);
    end
    xs[0] = 7; ws[0] = 9;
    run_job(1, 0, 0, 0, 1'b0, "post_reset_job");
  endtask

  task automatic test_random();
    int n;
    for (int j = 0; j < 20; j++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        xs[k] = (j % 4 == 3) ? $urandom_range(200, 255) : $urandom_range(0, 255);
        ws[k] = (j % 4 == 3) ? $urandom_range(200, 255) : $urandom_range(0, 255);
      end
      run_job(n, $urandom_range(0, MAXV), $urandom_range(0, 3), $urandom_range(0, 2),
              1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_saturation();
    test_len_zero();
    test_start_ignored();
    test_reset_mid_job();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
